uart_cpu_port: RTL

UART_CPU_PORT -- requirements
Module: uart_cpu_port

---
 rtl/uart_pkg.sv | 42 ++++
 rtl/uart_cpu_port.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART CPU port: register map, status bit
// positions and the access FSM encoding.
package uart_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA   = 2'd0,
    ADDR_STATUS = 2'd1,
    ADDR_CTRL   = 2'd2,
    ADDR_RSVD   = 2'd3
  } reg_addr_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_HOLD   = 2'd2
  } acc_state_e;

  localparam int STAT_RX_AVAIL = 0;
  localparam int STAT_TX_SPACE = 1;
  localparam int STAT_UNDR     = 2;
  localparam int STAT_DROP     = 3;
  localparam int STAT_IRQ      = 7;

  localparam int CTRL_RXIE = 0;
  localparam int CTRL_TXIE = 1;

  function automatic logic [7:0] status_byte(input logic rx_avail,
                                             input logic tx_space,
                                             input logic undr,
                                             input logic drop,
                                             input logic irq);
    logic [7:0] s;
    s                = 8'h00;
    s[STAT_RX_AVAIL] = rx_avail;
    s[STAT_TX_SPACE] = tx_space;
    s[STAT_UNDR]     = undr;
    s[STAT_DROP]     = drop;
    s[STAT_IRQ]      = irq;
    return s;
  endfunction

endpackage

// File: rtl/uart_cpu_port.sv
// CPU-side register port for a UART: one register access per chip-select
// assertion, FIFO push/pop strobes, sticky error flags and interrupt.
module uart_cpu_port
  import uart_pkg::*;
#(
  parameter logic [1:0] CTRL_RST = 2'b00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       we,
  input  logic [1:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       irq,
  output logic       rd_uart,
  output logic       wr_uart,
  output logic [7:0] w_data,
  input  logic [7:0] r_data,
  input  logic       rx_empty,
  input  logic       tx_full
);

  acc_state_e state_q, state_d;
  logic [7:0] dout_q, dout_d;
  logic [7:0] w_data_q, w_data_d;
  logic       rd_q, rd_d;
  logic       wr_q, wr_d;
  logic       irq_q, irq_d;
  logic       undr_q, undr_d;
  logic       drop_q, drop_d;
  logic [1:0] ctrl_q, ctrl_d;

  logic       access_go;
  logic       undr_set, drop_set, flag_clr;
  reg_addr_e  sel;

  // NOTE: every signal gets a default before any branch so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    dout_d    = dout_q;
    w_data_d  = w_data_q;
    ctrl_d    = ctrl_q;
    rd_d      = 1'b0;
    wr_d      = 1'b0;
    access_go = 1'b0;
    undr_set  = 1'b0;
    drop_set  = 1'b0;
    flag_clr  = 1'b0;
    sel       = reg_addr_e'(addr);

    case (state_q)
      ST_IDLE: begin
        if (cs) begin
          state_d   = ST_ACCESS;
          access_go = 1'b1;
        end
      end
      ST_ACCESS: state_d = ST_HOLD;
      ST_HOLD:   if (!cs) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // The access happens on the edge entering ACCESS, so strobes cover exactly that cycle.
    if (access_go) begin
      if (we) begin
        case (sel)
          ADDR_DATA: begin
            if (!tx_full) begin
              w_data_d = din;
              wr_d     = 1'b1;
            end else begin
              drop_set = 1'b1;
            end
          end
          ADDR_CTRL: ctrl_d = din[1:0];
          default: ;
        endcase
      end else begin
        case (sel)
          ADDR_DATA: begin
            if (!rx_empty) begin
              dout_d = r_data;
              rd_d   = 1'b1;
            end else begin
              dout_d   = 8'h00;
              undr_set = 1'b1;
            end
          end
          ADDR_STATUS: begin
            dout_d   = status_byte(~rx_empty, ~tx_full, undr_q, drop_q, irq_q);
            flag_clr = 1'b1;
          end
          ADDR_CTRL: dout_d = {6'b0, ctrl_q};
          default:   dout_d = 8'h00;
        endcase
      end
    end

    // Set beats clear so a simultaneous error is never lost.
    undr_d = undr_set | (undr_q & ~flag_clr);
    drop_d = drop_set | (drop_q & ~flag_clr);
    irq_d  = (ctrl_q[CTRL_RXIE] & ~rx_empty) | (ctrl_q[CTRL_TXIE] & ~tx_full)
           | undr_q | drop_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      dout_q   <= 8'h00;
      w_data_q <= 8'h00;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      irq_q    <= 1'b0;
      undr_q   <= 1'b0;
      drop_q   <= 1'b0;
      ctrl_q   <= CTRL_RST;
    end else begin
      state_q  <= state_d;
      dout_q   <= dout_d;
      w_data_q <= w_data_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      irq_q    <= irq_d;
      undr_q   <= undr_d;
      drop_q   <= drop_d;
      ctrl_q   <= ctrl_d;
    end
  end

  assign dout    = dout_q;
  assign w_data  = w_data_q;
  assign rd_uart = rd_q;
  assign wr_uart = wr_q;
  assign irq     = irq_q;

  // One access per cs assertion means a flag can never be set by the status read itself.
  assert property (@(posedge clk) disable iff (reset) !((undr_set || drop_set) && flag_clr));

endmodule
